// File: rtl/ball_engine.sv
// rtl/ball_engine.sv - breakout ball sprite: serve/play/lost control, per-frame motion, bounces, pixel enable
//
// Ports:
//   clk, reset       pixel clock, synchronous active-high reset
//   frame_tick       one-cycle pulse at the start of vertical blanking
//   x, y             current scan-out pixel
//   paddle_x         paddle left edge (stable during blanking)
//   serve            launch request (honoured only while serving)
//   block_hit        blocks stage reports ball/live-block overlap on this pixel
//   ball, ball_en    ball colour and registered coverage of (x,y)
//   ball_x, ball_y   ball top-left corner
//   life_lost        one-cycle pulse when the ball leaves through the bottom
//   playing          high while the ball is in play
module ball_engine #(
    parameter int          SCREEN_W   = 640,
    parameter int          SCREEN_H   = 480,
    parameter int          BORDER     = 8,
    parameter int          BALL_SIZE  = 8,
    parameter int          PADDLE_Y   = 448,
    parameter int          PADDLE_W   = 64,
    parameter int          SPEED      = 2,
    parameter logic [5:0]  BALL_COLOR = 6'b111111
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic [9:0] paddle_x,
    input  logic       serve,
    input  logic       block_hit,
    output logic [5:0] ball,
    output logic       ball_en,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       life_lost,
    output logic       playing
);

    typedef enum logic [1:0] {
        S_SERVE = 2'd0,
        S_PLAY  = 2'd1,
        S_LOST  = 2'd2
    } state_t;

    localparam logic signed [10:0] L_BORDER = 11'(BORDER);
    localparam logic signed [10:0] L_BALL   = 11'(BALL_SIZE);
    localparam logic signed [10:0] L_SPEED  = 11'(SPEED);
    localparam logic signed [10:0] L_RIGHT  = 11'(SCREEN_W - BORDER);
    localparam logic signed [10:0] L_PADY   = 11'(PADDLE_Y);
    localparam logic signed [10:0] L_PADW   = 11'(PADDLE_W);
    localparam logic signed [10:0] L_H      = 11'(SCREEN_H);

    localparam logic [9:0] RST_X    = 10'(SCREEN_W / 2 - BALL_SIZE / 2);
    localparam logic [9:0] REST_Y   = 10'(PADDLE_Y - BALL_SIZE);
    localparam logic [9:0] TRACK_DX = 10'(PADDLE_W / 2 - BALL_SIZE / 2);
    localparam logic [9:0] WALL_L_X = 10'(BORDER);
    localparam logic [9:0] WALL_R_X = 10'(SCREEN_W - BORDER - BALL_SIZE);
    localparam logic [9:0] WALL_T_Y = 10'(BORDER);

    state_t     r_state;
    logic [9:0] r_x;
    logic [9:0] r_y;
    logic       r_dx_neg;      // velocity magnitude is fixed, only the sign is stored
    logic       r_dy_neg;
    logic       r_hit;
    logic       r_ball_en;
    logic       r_life_lost;
    logic       r_playing;

    logic signed [10:0] w_bx;
    logic signed [10:0] w_by;
    logic signed [10:0] w_px;
    logic signed [10:0] w_nx;
    logic signed [10:0] w_ny;
    logic               w_dy_neg_eff;
    logic [9:0]         w_next_x;
    logic [9:0]         w_next_y;
    logic               w_next_dx_neg;
    logic               w_next_dy_neg;
    logic               w_exit;
    logic [9:0]         w_track_x;
    logic               w_on_ball;
    logic [10:0]        w_ux;
    logic [10:0]        w_uy;

    assign w_bx      = $signed({1'b0, r_x});
    assign w_by      = $signed({1'b0, r_y});
    assign w_px      = $signed({1'b0, paddle_x});
    assign w_track_x = paddle_x + TRACK_DX;

    // One frame of motion. A block hit in the tick cycle itself counts
    // alongside the sticky flag; several hits in a frame still flip dy once.
    always_comb begin
        w_dy_neg_eff  = r_dy_neg ^ (r_hit | block_hit);
        w_nx          = w_bx + (r_dx_neg ? -L_SPEED : L_SPEED);
        w_ny          = w_by + (w_dy_neg_eff ? -L_SPEED : L_SPEED);
        w_next_x      = w_nx[9:0];
        w_next_y      = w_ny[9:0];
        w_next_dx_neg = r_dx_neg;
        w_next_dy_neg = w_dy_neg_eff;

        if (w_nx < L_BORDER) begin
            w_next_x      = WALL_L_X;
            w_next_dx_neg = 1'b0;
        end else if (w_nx + L_BALL > L_RIGHT) begin
            w_next_x      = WALL_R_X;
            w_next_dx_neg = 1'b1;
        end

        if (w_ny < L_BORDER) begin
            w_next_y      = WALL_T_Y;
            w_next_dy_neg = 1'b0;
        end

        // Paddle only catches a falling ball that was fully above it last frame.
        if (!w_dy_neg_eff && (w_by + L_BALL <= L_PADY) && (w_ny + L_BALL > L_PADY) &&
            (w_nx + L_BALL > w_px) && (w_nx < w_px + L_PADW)) begin
            w_next_y      = REST_Y;
            w_next_dy_neg = 1'b1;
        end

        w_exit = (w_ny >= L_H);
    end

    assign w_ux      = {1'b0, x};
    assign w_uy      = {1'b0, y};
    assign w_on_ball = (w_ux >= {1'b0, r_x}) && (w_ux < {1'b0, r_x} + 11'(BALL_SIZE)) &&
                       (w_uy >= {1'b0, r_y}) && (w_uy < {1'b0, r_y} + 11'(BALL_SIZE));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_SERVE;
            r_x         <= RST_X;
            r_y         <= REST_Y;
            r_dx_neg    <= 1'b0;
            r_dy_neg    <= 1'b1;
            r_hit       <= 1'b0;
            r_ball_en   <= 1'b0;
            r_life_lost <= 1'b0;
            r_playing   <= 1'b0;
        end else begin
            r_ball_en   <= (r_state != S_LOST) && w_on_ball;
            r_life_lost <= 1'b0;
            case (r_state)
                S_SERVE: begin
                    r_hit <= 1'b0;
                    if (frame_tick) begin
                        r_x <= w_track_x;
                        r_y <= REST_Y;
                    end
                    if (serve) begin
                        r_state   <= S_PLAY;
                        r_playing <= 1'b1;
                        r_dx_neg  <= 1'b0;
                        r_dy_neg  <= 1'b1;
                    end
                end
                S_PLAY: begin
                    if (frame_tick) begin
                        r_hit <= 1'b0;
                        if (w_exit) begin
                            r_state     <= S_LOST;
                            r_playing   <= 1'b0;
                            r_life_lost <= 1'b1;
                        end else begin
                            r_x      <= w_next_x;
                            r_y      <= w_next_y;
                            r_dx_neg <= w_next_dx_neg;
                            r_dy_neg <= w_next_dy_neg;
                        end
                    end else if (block_hit) begin
                        r_hit <= 1'b1;
                    end
                end
                S_LOST: begin
                    r_hit <= 1'b0;
                    if (frame_tick) begin
                        r_state <= S_SERVE;
                        r_x     <= w_track_x;
                        r_y     <= REST_Y;
                    end
                end
                default: begin
                    r_state   <= S_SERVE;
                    r_playing <= 1'b0;
                end
            endcase
        end
    end

    assign ball      = BALL_COLOR;
    assign ball_en   = r_ball_en;
    assign ball_x    = r_x;
    assign ball_y    = r_y;
    assign life_lost = r_life_lost;
    assign playing   = r_playing;

endmodule

// File: tb/tb_ball_engine.sv
// tb/tb_ball_engine.sv - directed self-checking bench for ball_engine
module tb_ball_engine;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] paddle_x;
    logic       serve;
    logic       block_hit;
    logic [5:0] ball;
    logic       ball_en;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic       life_lost;
    logic       playing;

    int n_cmp = 0;
    int n_bad = 0;

    ball_engine dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .x          (x),
        .y          (y),
        .paddle_x   (paddle_x),
        .serve      (serve),
        .block_hit  (block_hit),
        .ball       (ball),
        .ball_en    (ball_en),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .life_lost  (life_lost),
        .playing    (playing)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_pos(input string tag, input int ex, input int ey);
        check({tag, "_x"}, 32'(ball_x), 32'(ex));
        check({tag, "_y"}, 32'(ball_y), 32'(ey));
    endtask

    // Called at a negedge; holds frame_tick for n rising edges.
    task automatic ticks(input int n);
        frame_tick = 1'b1;
        repeat (n) @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic pix(input string tag, input int px, input int py, input int exp);
        x = 10'(px);
        y = 10'(py);
        @(negedge clk);
        check(tag, 32'(ball_en), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; frame_tick = 1'b0; x = '0; y = '0;
        paddle_x = 10'd100; serve = 1'b0; block_hit = 1'b0;
        repeat (2) @(negedge clk);
        check_pos("rst", 316, 440);
        check("rst_playing", 32'(playing), 0);
        check("rst_lost", 32'(life_lost), 0);
        check("rst_en", 32'(ball_en), 0);
        check("color", 32'(ball), 63);
        reset = 1'b0;
        @(negedge clk);

        // Serve tracking and launch
        ticks(1);
        check_pos("track", 128, 440);
        check("track_playing", 32'(playing), 0);
        serve = 1'b1;
        @(negedge clk);
        serve = 1'b0;
        check("serve_playing", 32'(playing), 1);
        check_pos("serve_hold", 128, 440);
        ticks(1);
        check_pos("launch", 130, 438);

        // Pixel path around (130,438)
        pix("pix_l_out", 129, 438, 0);
        pix("pix_tl", 130, 438, 1);
        pix("pix_tr", 137, 438, 1);
        pix("pix_r_out", 138, 438, 0);
        pix("pix_t_out", 130, 437, 0);
        pix("pix_bl", 130, 445, 1);
        pix("pix_b_out", 130, 446, 0);
        pix("pix_br", 137, 445, 1);
        pix("pix_blank", 700, 500, 0);
        pix("pix_mid", 133, 441, 1);
        x = '0; y = '0;
        #1 check("pix_lag", 32'(ball_en), 1);
        @(negedge clk);
        check("pix_lag_off", 32'(ball_en), 0);

        // Five block hits in one frame: single inversion
        for (int i = 0; i < 5; i++) begin
            block_hit = 1'b1;
            @(negedge clk);
            block_hit = 1'b0;
            @(negedge clk);
        end
        ticks(1);
        check_pos("hit5", 132, 440);
        // Paddle bounce (also shows the hit flag was cleared)
        ticks(1);
        check_pos("paddle", 134, 440);
        ticks(1);
        check_pos("paddle_up", 136, 438);
        // Hit only in the tick cycle
        block_hit = 1'b1;
        ticks(1);
        block_hit = 1'b0;
        check_pos("hit_tick", 138, 440);

        // Paddle moved away: ball falls out
        paddle_x = 10'd300;
        ticks(1);
        check_pos("miss", 140, 442);
        ticks(18);
        check_pos("fall", 176, 478);
        check("fall_lost", 32'(life_lost), 0);
        ticks(1);
        check("lost_pulse", 32'(life_lost), 1);
        check("lost_playing", 32'(playing), 0);
        check_pos("lost_hold", 176, 478);
        pix("lost_gate", 178, 480 - 2, 0);
        check("lost_once", 32'(life_lost), 0);
        ticks(1);
        check_pos("reserve", 328, 440);
        check("reserve_playing", 32'(playing), 0);
        check("reserve_lost", 32'(life_lost), 0);

        // Serve and tick together near the right wall
        paddle_x = 10'd596;
        serve = 1'b1;
        ticks(1);
        serve = 1'b0;
        check_pos("serve_tick", 624, 440);
        check("serve_tick_playing", 32'(playing), 1);
        ticks(1);
        check_pos("right_wall", 624, 438);
        ticks(215);
        check_pos("to_top", 194, 8);
        ticks(1);
        check_pos("top_wall", 192, 8);
        ticks(92);
        check_pos("to_left", 8, 192);
        ticks(1);
        check_pos("left_wall", 8, 194);
        ticks(1);
        check_pos("left_away", 10, 196);

        // Reset mid-play
        pix("pre_rst_en", 12, 198, 1);
        reset = 1'b1;
        @(negedge clk);
        check_pos("mid_rst", 316, 440);
        check("mid_rst_playing", 32'(playing), 0);
        check("mid_rst_en", 32'(ball_en), 0);
        check("mid_rst_lost", 32'(life_lost), 0);
        reset = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
